proc_sequencer: RTL

Command sequencer for the image-processing chain. It sits between the operation buttons and the read/process and write units. It turns button presses into one processing run at a time: it latches brightness, threshold and operation settings, issues a start pulse, and waits for the process-done and write-done handshakes. It also counts completed runs and flags stalled runs with a timeout.

---
 rtl/proc_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/proc_sequencer.sv
// Command sequencer: turns button presses into single processing runs, latches
// brightness/threshold/operation settings and tracks the process/write handshakes.
module proc_sequencer #(
  parameter int unsigned BRI_STEP       = 16,
  parameter int unsigned THR_STEP       = 16,
  parameter int unsigned THR_INIT       = 128,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_W           = 20
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       btn_bri_up,
  input  logic       btn_bri_dn,
  input  logic       btn_thr_up,
  input  logic       btn_thr_dn,
  input  logic       btn_inv,
  input  logic       ctrl_done,
  input  logic       write_done,
  output logic       proc_start,
  output logic [2:0] op_sel,
  output logic [7:0] bri_val,
  output logic [7:0] thr_val,
  output logic       busy,
  output logic       run_done,
  output logic       err_timeout,
  output logic [7:0] run_count
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WAIT_PROC, ST_WAIT_WRITE, ST_DONE, ST_ERROR
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_BRI_UP, CMD_BRI_DN, CMD_THR_UP, CMD_THR_DN, CMD_INV
  } cmd_e;

  localparam logic [2:0] OP_NONE    = 3'd0;
  localparam logic [2:0] OP_BRI_ADD = 3'd1;
  localparam logic [2:0] OP_BRI_SUB = 3'd2;
  localparam logic [2:0] OP_THRESH  = 3'd3;
  localparam logic [2:0] OP_INVERT  = 3'd4;

  localparam logic signed [9:0] BRI_STEP_S = 10'(BRI_STEP);
  localparam logic signed [9:0] BRI_MAX    = 10'sd255;
  localparam logic signed [9:0] BRI_MIN    = -10'sd255;
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  // Button capture: bit order is also the priority order, MSB first.
  logic [4:0] btn_raw;
  logic [4:0] sync1_q, sync2_q, prev_q;
  logic [4:0] btn_rise;

  assign btn_raw  = {btn_inv, btn_thr_up, btn_thr_dn, btn_bri_up, btn_bri_dn};
  assign btn_rise = sync2_q & ~prev_q;

  // NOTE: sequential state is always written with <= so every flop samples the
  // pre-edge value of its neighbours; the async reset clears every flop here.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  cmd_e evt_cmd;

  // NOTE: every signal assigned in always_comb gets a default first so that no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    evt_cmd = CMD_NONE;
    if      (btn_rise[4]) evt_cmd = CMD_INV;
    else if (btn_rise[3]) evt_cmd = CMD_THR_UP;
    else if (btn_rise[2]) evt_cmd = CMD_THR_DN;
    else if (btn_rise[1]) evt_cmd = CMD_BRI_UP;
    else if (btn_rise[0]) evt_cmd = CMD_BRI_DN;
  end

  state_e           state_q;
  cmd_e             pend_q;
  logic             launch;
  logic             start_q, busy_q, done_q, err_q;
  logic [2:0]       op_q;
  logic signed [8:0] bri_q;
  logic [7:0]       bri_val_q, thr_q, cnt_q;
  logic [TO_W-1:0]  to_q;
  logic             ctrl_prev_q, wr_prev_q;
  logic             ctrl_rise, wr_rise, to_hit;

  assign launch    = ((state_q == ST_IDLE) || (state_q == ST_ERROR)) && (pend_q != CMD_NONE);
  assign ctrl_rise = ctrl_done & ~ctrl_prev_q;
  assign wr_rise   = write_done & ~wr_prev_q;
  assign to_hit    = (to_q == TO_LAST);

  // A fresh event always wins over clearing on launch, so nothing is lost.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q      <= CMD_NONE;
      ctrl_prev_q <= 1'b0;
      wr_prev_q   <= 1'b0;
    end else begin
      ctrl_prev_q <= ctrl_done;
      wr_prev_q   <= write_done;
      if (evt_cmd != CMD_NONE) pend_q <= evt_cmd;
      else if (launch)         pend_q <= CMD_NONE;
    end
  end

  // Settings the pending command would produce if launched now.
  logic signed [9:0] bri_wide, bri_inc, bri_dec;
  logic [8:0]        thr_inc;
  logic signed [8:0] bri_nxt;
  logic [7:0]        thr_nxt, bri_val_nxt;
  logic [2:0]        op_nxt;

  assign bri_wide = {bri_q[8], bri_q};
  assign bri_inc  = bri_wide + BRI_STEP_S;
  assign bri_dec  = bri_wide - BRI_STEP_S;
  assign thr_inc  = {1'b0, thr_q} + 9'(THR_STEP);

  always_comb begin
    bri_nxt = bri_q;
    thr_nxt = thr_q;
    op_nxt  = OP_NONE;
    case (pend_q)
      CMD_BRI_UP: begin
        bri_nxt = (bri_inc > BRI_MAX) ? 9'sd255 : bri_inc[8:0];
        op_nxt  = bri_nxt[8] ? OP_BRI_SUB : OP_BRI_ADD;
      end
      CMD_BRI_DN: begin
        bri_nxt = (bri_dec < BRI_MIN) ? -9'sd255 : bri_dec[8:0];
        op_nxt  = bri_nxt[8] ? OP_BRI_SUB : OP_BRI_ADD;
      end
      CMD_THR_UP: begin
        thr_nxt = thr_inc[8] ? 8'hFF : thr_inc[7:0];
        op_nxt  = OP_THRESH;
      end
      CMD_THR_DN: begin
        thr_nxt = (thr_q < 8'(THR_STEP)) ? 8'h00 : thr_q - 8'(THR_STEP);
        op_nxt  = OP_THRESH;
      end
      CMD_INV:    op_nxt = OP_INVERT;
      default:    op_nxt = OP_NONE;
    endcase
    bri_val_nxt = bri_nxt[8] ? 8'(-bri_nxt) : bri_nxt[7:0];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      op_q      <= OP_NONE;
      bri_q     <= '0;
      bri_val_q <= '0;
      thr_q     <= 8'(THR_INIT);
      cnt_q     <= '0;
      to_q      <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (launch) begin
            state_q   <= ST_START;
            start_q   <= 1'b1;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            op_q      <= op_nxt;
            bri_q     <= bri_nxt;
            bri_val_q <= bri_val_nxt;
            thr_q     <= thr_nxt;
          end
        end
        ST_START: begin
          state_q <= ST_WAIT_PROC;
          to_q    <= '0;
        end
        ST_WAIT_PROC: begin
          if (ctrl_rise && wr_rise) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (ctrl_rise) begin
            state_q <= ST_WAIT_WRITE;
            to_q    <= '0;
          end else if (to_hit) begin
            state_q <= ST_ERROR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        ST_WAIT_WRITE: begin
          if (wr_rise) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (to_hit) begin
            state_q <= ST_ERROR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= cnt_q + 8'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign proc_start  = start_q;
  assign op_sel      = op_q;
  assign bri_val     = bri_val_q;
  assign thr_val     = thr_q;
  assign busy        = busy_q;
  assign run_done    = done_q;
  assign err_timeout = err_q;
  assign run_count   = cnt_q;

endmodule
